// File: rtl/nx_stream_arbiter_wrr_pkg.sv
// Shared helpers for the weighted round-robin stream arbiter and its input FIFOs.
package nx_stream_arbiter_wrr_pkg;

  // base < n and step <= n, so a single conditional subtract wraps any n.
  function automatic int unsigned wrap_add(input int unsigned base,
                                           input int unsigned step,
                                           input int unsigned n);
    int unsigned s;
    s = base + step;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/nx_stream_fifo.sv
// Per-input beat buffer: power-of-2 depth ring with occupancy count, no push/pop bypass.
module nx_stream_fifo
  import nx_stream_arbiter_wrr_pkg::*;
#(
  parameter int STREAM_WIDTH = 32,
  parameter int DEPTH        = 2,
  localparam int AW          = $clog2(DEPTH),
  localparam int CW          = AW + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [STREAM_WIDTH-1:0] wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [STREAM_WIDTH-1:0] rd_data,
  input  logic                    rd_en,
  output logic [CW-1:0]           count
);

  logic [STREAM_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic                    push;
  logic                    pop;

  // Ready ignores a same-cycle pop so a full FIFO never accepts while draining.
  assign wr_ready = rst_i && (count != CW'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_en && (count != '0);
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/nx_stream_arbiter_wrr.sv
// Merges INPUTS buffered streams into one, granting by weighted round-robin
// (weight+1 consecutive beats per grant); arb_dir_o tags each beat's source.
module nx_stream_arbiter_wrr
  import nx_stream_arbiter_wrr_pkg::*;
#(
  parameter int STREAM_WIDTH = 32,
  parameter int INPUTS       = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int WEIGHT_WIDTH = 3,
  parameter int IDX_WIDTH    = $clog2(INPUTS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [INPUTS*STREAM_WIDTH-1:0] in_data_i,
  input  logic [INPUTS-1:0]              in_valid_i,
  output logic [INPUTS-1:0]              in_ready_o,
  input  logic [INPUTS*WEIGHT_WIDTH-1:0] weight_i,
  output logic [STREAM_WIDTH-1:0]        arb_data_o,
  output logic [IDX_WIDTH-1:0]           arb_dir_o,
  output logic                           arb_valid_o,
  input  logic                           arb_ready_i,
  output logic                           idle_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0]           cnt  [INPUTS];
  logic [STREAM_WIDTH-1:0] head [INPUTS];
  logic [INPUTS-1:0]       pop_sel;
  logic [INPUTS-1:0]       nonempty;
  logic [INPUTS-1:0]       avail;

  logic [IDX_WIDTH-1:0]    choice_q, choice_d, pick;
  logic                    locked_q, locked_d, found;
  logic [WEIGHT_WIDTH-1:0] beats_q, beats_d, cur_weight;
  logic [IDX_WIDTH-1:0]    scan_idx;
  logic                    hs;

  assign arb_valid_o = rst_i && locked_q;
  assign hs          = arb_valid_o && arb_ready_i;
  assign arb_dir_o   = rst_i ? choice_q : '0;
  assign arb_data_o  = head[choice_q];
  assign cur_weight  = weight_i[int'(choice_q)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  assign idle_o      = !rst_i || ((nonempty == '0) && !locked_q);

  for (genvar i = 0; i < INPUTS; i++) begin : g_in
    assign pop_sel[i]  = hs && (choice_q == IDX_WIDTH'(i));
    assign nonempty[i] = (cnt[i] != '0);
    // Occupancy after this cycle's pop; a same-cycle push is deliberately not counted.
    assign avail[i]    = (cnt[i] > CW'(pop_sel[i]));

    nx_stream_fifo #(
      .STREAM_WIDTH (STREAM_WIDTH),
      .DEPTH        (FIFO_DEPTH)
    ) u_fifo (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_data  (in_data_i[i*STREAM_WIDTH +: STREAM_WIDTH]),
      .wr_valid (in_valid_i[i]),
      .wr_ready (in_ready_o[i]),
      .rd_data  (head[i]),
      .rd_en    (pop_sel[i]),
      .count    (cnt[i])
    );
  end

  always_comb begin
    choice_d = choice_q;
    locked_d = locked_q;
    beats_d  = beats_q;
    found    = 1'b0;
    pick     = choice_q;
    scan_idx = '0;
    // The current holder is visited last, giving every other input a turn first.
    for (int k = 1; k <= INPUTS; k++) begin
      scan_idx = IDX_WIDTH'(wrap_add(32'(choice_q), unsigned'(k), unsigned'(INPUTS)));
      if (!found && avail[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
    if (!locked_q || hs) begin
      if (hs && (beats_q < cur_weight) && avail[choice_q]) begin
        beats_d = beats_q + WEIGHT_WIDTH'(1);
      end else if (found) begin
        choice_d = pick;
        locked_d = 1'b1;
        beats_d  = '0;
      end else begin
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      choice_q <= '0;
      locked_q <= 1'b0;
      beats_q  <= '0;
    end else begin
      choice_q <= choice_d;
      locked_q <= locked_d;
      beats_q  <= beats_d;
    end
  end

endmodule

// File: tb/tb_nx_stream_arbiter_wrr.sv
// Bench for nx_stream_arbiter_wrr: a 4-input instance against a queue-based
// reference model, plus a 3-input instance for index wrap and mid-burst reset.
module tb_nx_stream_arbiter_wrr;

  localparam int SW = 32;
  localparam int NA = 4;
  localparam int DA = 8;
  localparam int WW = 3;
  localparam int NB = 3;
  localparam int DB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_a, rst_b;
  logic [NA*SW-1:0] a_in_data;
  logic [NA-1:0]    a_in_valid, a_in_ready;
  logic [NA*WW-1:0] a_weight;
  logic [SW-1:0]    a_data;
  logic [1:0]       a_dir;
  logic             a_valid, a_ready, a_idle;

  logic [NB*SW-1:0] b_in_data;
  logic [NB-1:0]    b_in_valid, b_in_ready;
  logic [NB*WW-1:0] b_weight;
  logic [SW-1:0]    b_data;
  logic [1:0]       b_dir;
  logic             b_valid, b_ready, b_idle;

  nx_stream_arbiter_wrr #(.STREAM_WIDTH(SW), .INPUTS(NA), .FIFO_DEPTH(DA), .WEIGHT_WIDTH(WW)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .in_data_i(a_in_data), .in_valid_i(a_in_valid),
    .in_ready_o(a_in_ready), .weight_i(a_weight), .arb_data_o(a_data), .arb_dir_o(a_dir),
    .arb_valid_o(a_valid), .arb_ready_i(a_ready), .idle_o(a_idle));

  nx_stream_arbiter_wrr #(.STREAM_WIDTH(SW), .INPUTS(NB), .FIFO_DEPTH(DB), .WEIGHT_WIDTH(WW)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .in_data_i(b_in_data), .in_valid_i(b_in_valid),
    .in_ready_o(b_in_ready), .weight_i(b_weight), .arb_data_o(b_data), .arb_dir_o(b_dir),
    .arb_valid_o(b_valid), .arb_ready_i(b_ready), .idle_o(b_idle));

  // Reference model of dut_a: one queue per input plus the grant holder.
  logic [SW-1:0] mq [NA][$];
  int            m_choice = 0;
  int            m_beats  = 0;
  bit            m_locked = 1'b0;

  logic [NA-1:0] e_ready;
  logic          e_valid, e_idle;
  logic [1:0]    e_dir;
  logic [SW-1:0] e_data;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic int wgt(input int i);
    return int'(a_weight[i*WW +: WW]);
  endfunction

  // Waits for the falling edge and derives the model's view of the outputs.
  task automatic sample();
    @(negedge clk);
    e_valid = rst_a && m_locked;
    e_dir   = rst_a ? 2'(m_choice) : 2'd0;
    e_data  = '0;
    if (e_valid && mq[m_choice].size() > 0) e_data = mq[m_choice][0];
    e_idle  = !m_locked;
    for (int i = 0; i < NA; i++) begin
      if (mq[i].size() != 0) e_idle = 1'b0;
      e_ready[i] = rst_a && (mq[i].size() < DA);
    end
    if (!rst_a) e_idle = 1'b1;
  endtask

  // Applies the arbitration rules to the model, then crosses the rising edge.
  task automatic adv();
    bit [NA-1:0] rdy;
    bit          hs, found;
    int          c, j;
    if (!rst_a) begin
      for (int i = 0; i < NA; i++) mq[i].delete();
      m_choice = 0; m_locked = 1'b0; m_beats = 0;
    end else begin
      for (int i = 0; i < NA; i++) rdy[i] = (mq[i].size() < DA);
      hs = m_locked && a_ready;
      c  = m_choice;
      if (hs) void'(mq[c].pop_front());
      if (!m_locked || hs) begin
        if (hs && m_beats < wgt(c) && mq[c].size() > 0) begin
          m_beats++;
        end else begin
          found = 1'b0;
          for (int k = 1; k <= NA; k++) begin
            j = (c + k) % NA;
            if (!found && mq[j].size() > 0) begin
              found = 1'b1;
              m_choice = j;
            end
          end
          m_locked = found;
          if (found) m_beats = 0;
        end
      end
      for (int i = 0; i < NA; i++)
        if (a_in_valid[i] && rdy[i]) mq[i].push_back(a_in_data[i*SW +: SW]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    a_in_valid = '1; b_in_valid = '1; a_ready = 1'b0; b_ready = 1'b0;
    a_in_data = '0; b_in_data = '0; a_weight = '0; b_weight = '0;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_cmp++; if (a_in_ready !== 4'h0) begin n_fail++; $display("FAIL reset_in_ready c%0d: got %h want 0", c, a_in_ready); end
      n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid c%0d: got %b want 0", c, a_valid); end
      n_cmp++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle c%0d: got %b want 1", c, a_idle); end
      n_cmp++; if (a_dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir c%0d: got %0d want 0", c, a_dir); end
      n_cmp++; if (b_in_ready !== 3'h0) begin n_fail++; $display("FAIL reset_b_in_ready c%0d: got %h want 0", c, b_in_ready); end
      adv();
    end
    rst_a = 1'b1; rst_b = 1'b1; a_in_valid = '0; b_in_valid = '0;
    sample();
    n_cmp++; if (a_in_ready !== 4'hF) begin n_fail++; $display("FAIL release_in_ready: got %h want f", a_in_ready); end
    n_cmp++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL release_idle: got %b want 1", a_idle); end
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", a_valid); end
    n_cmp++; if (b_in_ready !== 3'h7) begin n_fail++; $display("FAIL release_b_in_ready: got %h want 7", b_in_ready); end
    adv();
  endtask

  task automatic test_single();
    a_ready = 1'b1;
    a_in_valid = 4'b0100;
    a_in_data[2*SW +: SW] = 32'hA5;
    sample();
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL single_n0_valid: got %b want 0", a_valid); end
    adv();
    a_in_valid = '0;
    sample();
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL single_n1_valid: got %b want 0", a_valid); end
    adv();
    sample();
    n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL single_n2_valid: got %b want 1", a_valid); end
    n_cmp++; if (a_data !== 32'hA5) begin n_fail++; $display("FAIL single_n2_data: got %h want a5", a_data); end
    n_cmp++; if (a_dir !== 2'd2) begin n_fail++; $display("FAIL single_n2_dir: got %0d want 2", a_dir); end
    adv();
    sample();
    n_cmp++; if (a_idle !== 1'b1) begin n_fail++; $display("FAIL single_n3_idle: got %b want 1", a_idle); end
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL single_n3_valid: got %b want 0", a_valid); end
    adv();
  endtask

  task automatic test_round_robin();
    int exp_dir [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    a_weight = '0; a_ready = 1'b0;
    // Input 0 lands first so it holds the grant before the others arrive.
    a_in_valid = 4'b0001; a_in_data[0 +: SW] = 32'h000;
    adv();
    a_in_valid = 4'b1111;
    a_in_data[0 +: SW] = 32'h001;
    for (int i = 1; i < NA; i++) a_in_data[i*SW +: SW] = (i << 8);
    adv();
    a_in_valid = 4'b1110;
    for (int i = 1; i < NA; i++) a_in_data[i*SW +: SW] = (i << 8) | 1;
    sample();
    n_cmp++; if (a_valid !== 1'b1 || a_dir !== 2'd0) begin n_fail++; $display("FAIL rr_locked: valid %b dir %0d want 1/0", a_valid, a_dir); end
    adv();
    a_in_valid = '0; a_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sample();
      n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid k%0d: got %b want 1", k, a_valid); end
      n_cmp++; if (a_dir !== 2'(exp_dir[k])) begin n_fail++; $display("FAIL rr_dir k%0d: got %0d want %0d", k, a_dir, exp_dir[k]); end
      n_cmp++; if (a_data !== 32'((exp_dir[k] << 8) | (k / 4))) begin n_fail++; $display("FAIL rr_data k%0d: got %h want %h", k, a_data, (exp_dir[k] << 8) | (k / 4)); end
      adv();
    end
    sample();
    n_cmp++; if (a_valid !== 1'b0 || a_idle !== 1'b1) begin n_fail++; $display("FAIL rr_drained: valid %b idle %b want 0/1", a_valid, a_idle); end
    adv();
  endtask

  task automatic test_weighted();
    int exp_dir [10] = '{0, 3, 3, 3, 0, 3, 3, 0, 0, 0};
    int bc [NA];
    int oc [NA];
    for (int i = 0; i < NA; i++) begin bc[i] = 0; oc[i] = 0; end
    a_weight = '0; a_weight[3*WW +: WW] = 3'd2; a_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      a_in_valid = (c == 0) ? 4'b0001 : (c == 5) ? 4'b1000 : 4'b1001;
      for (int i = 0; i < NA; i++) begin
        a_in_data[i*SW +: SW] = (i << 8) | bc[i];
        if (a_in_valid[i]) bc[i]++;
      end
      adv();
    end
    a_in_valid = '0; a_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sample();
      n_cmp++; if (a_valid !== 1'b1) begin n_fail++; $display("FAIL wrr_valid k%0d: got %b want 1", k, a_valid); end
      n_cmp++; if (a_dir !== 2'(exp_dir[k])) begin n_fail++; $display("FAIL wrr_dir k%0d: got %0d want %0d", k, a_dir, exp_dir[k]); end
      n_cmp++; if (a_data !== 32'((exp_dir[k] << 8) | oc[exp_dir[k]])) begin n_fail++; $display("FAIL wrr_data k%0d: got %h want %h", k, a_data, (exp_dir[k] << 8) | oc[exp_dir[k]]); end
      oc[exp_dir[k]]++;
      adv();
    end
    sample();
    n_cmp++; if (a_valid !== 1'b0) begin n_fail++; $display("FAIL wrr_drained: got %b want 0", a_valid); end
    adv();
  endtask

  task automatic test_stall();
    logic [1:0]    held_dir;
    logic [SW-1:0] held_data;
    held_dir = '0; held_data = '0;
    a_weight = '0; a_ready = 1'b0; a_in_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NA; i++) a_in_data[i*SW +: SW] = $urandom();
      sample();
      n_cmp++; if (a_in_ready !== e_ready) begin n_fail++; $display("FAIL stall_in_ready c%0d: got %h want %h", c, a_in_ready, e_ready); end
      if (c == 2) begin
        held_dir = a_dir; held_data = a_data;
        n_cmp++; if (a_valid !== 1'b1 || a_dir !== e_dir || a_data !== e_data) begin n_fail++; $display("FAIL stall_grant: valid %b dir %0d data %h want 1/%0d/%h", a_valid, a_dir, a_data, e_dir, e_data); end
      end else if (c > 2) begin
        n_cmp++; if (a_valid !== 1'b1 || a_dir !== held_dir || a_data !== held_data) begin n_fail++; $display("FAIL stall_hold c%0d: valid %b dir %0d data %h want 1/%0d/%h", c, a_valid, a_dir, a_data, held_dir, held_data); end
      end
      if (c == 11) begin
        n_cmp++; if (a_in_ready !== 4'h0) begin n_fail++; $display("FAIL stall_full: got %h want 0", a_in_ready); end
      end
      adv();
    end
    a_in_valid = '0; a_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      sample();
      n_cmp++; if (a_valid !== e_valid || a_dir !== e_dir) begin n_fail++; $display("FAIL drain_ctl c%0d: valid %b dir %0d want %b/%0d", c, a_valid, a_dir, e_valid, e_dir); end
      if (e_valid) begin
        n_cmp++; if (a_data !== e_data) begin n_fail++; $display("FAIL drain_data c%0d: got %h want %h", c, a_data, e_data); end
      end
      adv();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_a = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < NA; i++) begin
        a_in_valid[i] = ($urandom_range(0, 2) == 0);
        a_in_data[i*SW +: SW] = $urandom();
      end
      a_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) a_weight = 12'($urandom());
      sample();
      n_cmp++; if (a_in_ready !== e_ready) begin n_fail++; $display("FAIL rnd_in_ready c%0d: got %h want %h", c, a_in_ready, e_ready); end
      n_cmp++; if (a_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, a_valid, e_valid); end
      n_cmp++; if (a_dir !== e_dir) begin n_fail++; $display("FAIL rnd_dir c%0d: got %0d want %0d", c, a_dir, e_dir); end
      n_cmp++; if (a_idle !== e_idle) begin n_fail++; $display("FAIL rnd_idle c%0d: got %b want %b", c, a_idle, e_idle); end
      if (e_valid) begin
        n_cmp++; if (a_data !== e_data) begin n_fail++; $display("FAIL rnd_data c%0d: got %h want %h", c, a_data, e_data); end
      end
      adv();
    end
    rst_a = 1'b1; a_in_valid = '0;
  endtask

  task automatic test_wrap_reset();
    b_weight = '0; b_ready = 1'b0;
    b_in_valid = 3'b100; b_in_data[2*SW +: SW] = 32'h22;
    adv();
    b_in_valid = '0;
    sample();
    n_cmp++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_pre_valid: got %b want 0", b_valid); end
    adv();
    b_in_valid = 3'b001; b_in_data[0 +: SW] = 32'h11;
    sample();
    n_cmp++; if (b_valid !== 1'b1 || b_dir !== 2'd2 || b_data !== 32'h22) begin n_fail++; $display("FAIL wrap_grant2: valid %b dir %0d data %h want 1/2/22", b_valid, b_dir, b_data); end
    adv();
    b_in_valid = '0; b_ready = 1'b1;
    sample();
    n_cmp++; if (b_valid !== 1'b1 || b_dir !== 2'd2) begin n_fail++; $display("FAIL wrap_hs2: valid %b dir %0d want 1/2", b_valid, b_dir); end
    adv();
    b_ready = 1'b0; b_in_valid = 3'b011;
    b_in_data[0 +: SW] = 32'h12; b_in_data[SW +: SW] = 32'h13;
    sample();
    n_cmp++; if (b_valid !== 1'b1 || b_dir !== 2'd0 || b_data !== 32'h11) begin n_fail++; $display("FAIL wrap_to0: valid %b dir %0d data %h want 1/0/11", b_valid, b_dir, b_data); end
    adv();
    rst_b = 1'b0; b_in_valid = '0;
    sample();
    n_cmp++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", b_valid); end
    adv();
    rst_b = 1'b1;
    sample();
    n_cmp++; if (b_valid !== 1'b0 || b_idle !== 1'b1) begin n_fail++; $display("FAIL midrst_release: valid %b idle %b want 0/1", b_valid, b_idle); end
    n_cmp++; if (b_in_ready !== 3'h7) begin n_fail++; $display("FAIL midrst_in_ready: got %h want 7", b_in_ready); end
    adv();
    sample();
    n_cmp++; if (b_valid !== 1'b0 || b_idle !== 1'b1) begin n_fail++; $display("FAIL midrst_empty: valid %b idle %b want 0/1", b_valid, b_idle); end
    adv();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_weighted();
    test_stall();
    test_random();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
